vga_plot_arbiter: RTL and testbench

- Shares the single pixel-write port of the VGA adapter (VGA_X, VGA_Y, VGA_COLOR, plot) between two pixel requesters (req0: CPU store path, req1: draw/sprite engine) and a built-in full-screen clear sequencer.
- Sits between the requesters and the VGA adapter inside top.
- Round-robin fairness between requesters; clear has absolute priority once started and runs to completion.

---
 rtl/vga_pkg.sv | 14 +
 rtl/vga_plot_arbiter_if.sv | 17 +
 rtl/vga_clear_counter.sv | 41 ++++
 rtl/vga_plot_arbiter.sv | 129 ++++++++++++
 tb/tb_vga_plot_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA pixel-write path: default raster size, field widths
// and the arbiter state encoding.
package vga_pkg;

    localparam int unsigned DEF_H_RES = 640;
    localparam int unsigned DEF_V_RES = 480;
    localparam int unsigned X_W       = 10;
    localparam int unsigned Y_W       = 9;
    localparam int unsigned COLOR_W   = 24;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StClear = 1'b1;

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Pixel request channel: valid/ready handshake carrying one (x, y, colour) write.
interface vga_plot_arbiter_if
    import vga_pkg::*;
#(
    parameter int unsigned COLOR_W = vga_pkg::COLOR_W
);

    logic               valid;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] color;
    logic               ready;

    modport master (output valid, x, y, color, input ready);
    modport slave  (input valid, x, y, color, output ready);

endinterface

// File: rtl/vga_clear_counter.sv
// Raster-order cx/cy counter for the full-screen clear; last flags the final pixel.
module vga_clear_counter
    import vga_pkg::*;
#(
    parameter int unsigned H_RES = vga_pkg::DEF_H_RES,
    parameter int unsigned V_RES = vga_pkg::DEF_V_RES
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           start_i,
    input  logic           en_i,
    output logic [X_W-1:0] cx_o,
    output logic [Y_W-1:0] cy_o,
    output logic           last_o
);

    localparam logic [X_W-1:0] XLast = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] YLast = Y_W'(V_RES - 1);

    logic [X_W-1:0] cx_q;
    logic [Y_W-1:0] cy_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || start_i) begin
            cx_q <= '0;
            cy_q <= '0;
        end else if (en_i) begin
            if (cx_q == XLast) begin
                cx_q <= '0;
                cy_q <= (cy_q == YLast) ? '0 : cy_q + 1'b1;
            end else begin
                cx_q <= cx_q + 1'b1;
            end
        end
    end

    assign cx_o   = cx_q;
    assign cy_o   = cy_q;
    assign last_o = (cx_q == XLast) && (cy_q == YLast);

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the VGA adapter's single pixel-write port between two round-robin requesters
// and a full-screen clear sequencer that, once started, owns the port until done.
module vga_plot_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned H_RES   = vga_pkg::DEF_H_RES,
    parameter int unsigned V_RES   = vga_pkg::DEF_V_RES,
    parameter int unsigned COLOR_W = vga_pkg::COLOR_W
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               clear_req,
    input  logic [COLOR_W-1:0] clear_color,
    vga_plot_arbiter_if.slave  req0,
    vga_plot_arbiter_if.slave  req1,
    output logic [X_W-1:0]     VGA_X,
    output logic [Y_W-1:0]     VGA_Y,
    output logic [COLOR_W-1:0] VGA_COLOR,
    output logic               plot,
    output logic               busy,
    output logic               clear_done,
    output logic               oob_err
);

    logic [0:0]         state_q;
    logic               rr_q;        // 1 = req1 favoured on a tie
    logic [COLOR_W-1:0] clr_color_q;

    logic               gnt0, gnt1, acc, both, in_range;
    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic [COLOR_W-1:0] sel_color;

    logic               clr_start, clr_en, clr_last;
    logic [X_W-1:0]     cx;
    logic [Y_W-1:0]     cy;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == StIdle) begin
            if (req0.valid && (!req1.valid || !rr_q)) begin
                gnt0 = 1'b1;
            end else if (req1.valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign req0.ready = gnt0;
    assign req1.ready = gnt1;
    assign acc        = gnt0 | gnt1;
    assign both       = req0.valid & req1.valid;

    assign sel_x     = gnt1 ? req1.x     : req0.x;
    assign sel_y     = gnt1 ? req1.y     : req0.y;
    assign sel_color = gnt1 ? req1.color : req0.color;
    // Compare at 32 bits so H_RES = 1024 / V_RES = 512 do not truncate to zero.
    assign in_range  = (32'(sel_x) < H_RES) && (32'(sel_y) < V_RES);

    assign clr_start = (state_q == StIdle) && clear_req;
    assign clr_en    = (state_q == StClear);

    vga_clear_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_clear_counter (
        .clk_i   (CLOCK_50),
        .reset_i (reset),
        .start_i (clr_start),
        .en_i    (clr_en),
        .cx_o    (cx),
        .cy_o    (cy),
        .last_o  (clr_last)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= StIdle;
            rr_q        <= 1'b0;
            clr_color_q <= '0;
            VGA_X       <= '0;
            VGA_Y       <= '0;
            VGA_COLOR   <= '0;
            plot        <= 1'b0;
            busy        <= 1'b0;
            clear_done  <= 1'b0;
            oob_err     <= 1'b0;
        end else begin
            plot       <= 1'b0;
            clear_done <= 1'b0;
            // busy tracks the registered clear writes, so it spans exactly the clear plots.
            busy       <= (state_q == StClear);
            case (state_q)
                StIdle: begin
                    if (acc) begin
                        if (both) begin
                            rr_q <= ~rr_q;
                        end
                        if (in_range) begin
                            VGA_X     <= sel_x;
                            VGA_Y     <= sel_y;
                            VGA_COLOR <= sel_color;
                            plot      <= 1'b1;
                        end else begin
                            oob_err <= 1'b1;
                        end
                    end
                    if (clear_req) begin
                        state_q     <= StClear;
                        clr_color_q <= clear_color;
                    end
                end
                StClear: begin
                    VGA_X     <= cx;
                    VGA_Y     <= cy;
                    VGA_COLOR <= clr_color_q;
                    plot      <= 1'b1;
                    if (clr_last) begin
                        state_q    <= StIdle;
                        clear_done <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench: default-size instance for arbitration/range checks, and a
// 4x3 instance for the clear sequencer corner cases.
module tb_vga_plot_arbiter;
    import vga_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic        b_reset, b_clear_req;
    logic [23:0] b_clear_color;
    logic [9:0]  b_vga_x;
    logic [8:0]  b_vga_y;
    logic [23:0] b_vga_color;
    logic        b_plot, b_busy, b_clear_done, b_oob;

    logic        s_reset, s_clear_req;
    logic [23:0] s_clear_color;
    logic [9:0]  s_vga_x;
    logic [8:0]  s_vga_y;
    logic [23:0] s_vga_color;
    logic        s_plot, s_busy, s_clear_done, s_oob;

    vga_plot_arbiter_if #(.COLOR_W(24)) b_req0 ();
    vga_plot_arbiter_if #(.COLOR_W(24)) b_req1 ();
    vga_plot_arbiter_if #(.COLOR_W(24)) s_req0 ();
    vga_plot_arbiter_if #(.COLOR_W(24)) s_req1 ();

    vga_plot_arbiter dut_big (
        .CLOCK_50    (clk),
        .reset       (b_reset),
        .clear_req   (b_clear_req),
        .clear_color (b_clear_color),
        .req0        (b_req0),
        .req1        (b_req1),
        .VGA_X       (b_vga_x),
        .VGA_Y       (b_vga_y),
        .VGA_COLOR   (b_vga_color),
        .plot        (b_plot),
        .busy        (b_busy),
        .clear_done  (b_clear_done),
        .oob_err     (b_oob)
    );

    vga_plot_arbiter #(.H_RES(4), .V_RES(3), .COLOR_W(24)) dut_small (
        .CLOCK_50    (clk),
        .reset       (s_reset),
        .clear_req   (s_clear_req),
        .clear_color (s_clear_color),
        .req0        (s_req0),
        .req1        (s_req1),
        .VGA_X       (s_vga_x),
        .VGA_Y       (s_vga_y),
        .VGA_COLOR   (s_vga_color),
        .plot        (s_plot),
        .busy        (s_busy),
        .clear_done  (s_clear_done),
        .oob_err     (s_oob)
    );

    typedef struct {
        logic        v0;
        logic [9:0]  x0;
        logic [8:0]  y0;
        logic [23:0] c0;
        logic        v1;
        logic [9:0]  x1;
        logic [8:0]  y1;
        logic [23:0] c1;
        logic        r0;
        logic        r1;
        logic        plot;
        logic [9:0]  ex;
        logic [8:0]  ey;
        logic [23:0] ec;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Random-phase model state
    logic        p[2];
    logic [9:0]  px[2];
    logic [8:0]  py[2];
    logic [23:0] pc[2];
    int          fav, g;
    logic        exp_plot, exp_oob;
    logic [9:0]  last_x;
    logic [8:0]  last_y;
    logic [23:0] last_c;

    // Clear-phase logs
    logic [9:0]  lx[32];
    logic [8:0]  ly[32];
    logic [23:0] lc[32];
    logic        lb[32];
    int nplots, done_cnt, done_cyc, done_idx, busy_cnt, early_ready, nclr, stray;
    logic r1_seen, req1_pending;

    initial begin
        b_reset = 1'b1; b_clear_req = 1'b0; b_clear_color = '0;
        s_reset = 1'b1; s_clear_req = 1'b0; s_clear_color = '0;
        b_req0.valid = 1'b0; b_req0.x = '0; b_req0.y = '0; b_req0.color = '0;
        b_req1.valid = 1'b0; b_req1.x = '0; b_req1.y = '0; b_req1.color = '0;
        s_req0.valid = 1'b0; s_req0.x = '0; s_req0.y = '0; s_req0.color = '0;
        s_req1.valid = 1'b0; s_req1.x = '0; s_req1.y = '0; s_req1.color = '0;

        vecs[0] = '{1'b1, 10'd5, 9'd7, 24'hFF0000, 1'b0, 10'd0, 9'd0, 24'h0,
                    1'b1, 1'b0, 1'b1, 10'd5, 9'd7, 24'hFF0000};
        vecs[1] = '{1'b0, 10'd0, 9'd0, 24'h0, 1'b0, 10'd0, 9'd0, 24'h0,
                    1'b0, 1'b0, 1'b0, 10'd5, 9'd7, 24'hFF0000};
        vecs[2] = '{1'b1, 10'd10, 9'd20, 24'h0000AA, 1'b1, 10'd30, 9'd40, 24'h0000BB,
                    1'b1, 1'b0, 1'b1, 10'd10, 9'd20, 24'h0000AA};
        vecs[3] = '{1'b1, 10'd10, 9'd20, 24'h0000AA, 1'b1, 10'd30, 9'd40, 24'h0000BB,
                    1'b0, 1'b1, 1'b1, 10'd30, 9'd40, 24'h0000BB};
        vecs[4] = '{1'b1, 10'd10, 9'd20, 24'h0000AA, 1'b1, 10'd30, 9'd40, 24'h0000BB,
                    1'b1, 1'b0, 1'b1, 10'd10, 9'd20, 24'h0000AA};
        vecs[5] = '{1'b1, 10'd10, 9'd20, 24'h0000AA, 1'b1, 10'd30, 9'd40, 24'h0000BB,
                    1'b0, 1'b1, 1'b1, 10'd30, 9'd40, 24'h0000BB};
        vecs[6] = '{1'b0, 10'd0, 9'd0, 24'h0, 1'b0, 10'd0, 9'd0, 24'h0,
                    1'b0, 1'b0, 1'b0, 10'd30, 9'd40, 24'h0000BB};

        // Reset state of both instances
        repeat (3) @(posedge clk);
        #1;
        check("rst plot", 32'(b_plot), 32'd0);
        check("rst vga_x", 32'(b_vga_x), 32'd0);
        check("rst vga_y", 32'(b_vga_y), 32'd0);
        check("rst color", 32'(b_vga_color), 32'd0);
        check("rst busy", 32'(b_busy), 32'd0);
        check("rst done", 32'(b_clear_done), 32'd0);
        check("rst oob", 32'(b_oob), 32'd0);
        check("rst ready", 32'({b_req0.ready, b_req1.ready}), 32'd0);
        check("rst small plot/busy", 32'({s_plot, s_busy, s_clear_done, s_oob}), 32'd0);
        @(negedge clk);
        b_reset = 1'b0;
        s_reset = 1'b0;

        // Table: single request, then sustained dual requests alternating
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            b_req0.valid = vecs[i].v0; b_req0.x = vecs[i].x0;
            b_req0.y = vecs[i].y0; b_req0.color = vecs[i].c0;
            b_req1.valid = vecs[i].v1; b_req1.x = vecs[i].x1;
            b_req1.y = vecs[i].y1; b_req1.color = vecs[i].c1;
            #1;
            check($sformatf("vec%0d ready0", i), 32'(b_req0.ready), 32'(vecs[i].r0));
            check($sformatf("vec%0d ready1", i), 32'(b_req1.ready), 32'(vecs[i].r1));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d plot", i), 32'(b_plot), 32'(vecs[i].plot));
            check($sformatf("vec%0d x", i), 32'(b_vga_x), 32'(vecs[i].ex));
            check($sformatf("vec%0d y", i), 32'(b_vga_y), 32'(vecs[i].ey));
            check($sformatf("vec%0d color", i), 32'(b_vga_color), 32'(vecs[i].ec));
            check($sformatf("vec%0d oob", i), 32'(b_oob), 32'd0);
        end

        // Out-of-range requests are consumed without plotting and latch oob_err
        @(negedge clk);
        b_req0.valid = 1'b1; b_req0.x = 10'd640; b_req0.y = 9'd0; b_req0.color = 24'h123456;
        #1;
        check("oob x ready", 32'(b_req0.ready), 32'd1);
        @(posedge clk);
        #1;
        check("oob x plot", 32'(b_plot), 32'd0);
        check("oob x err", 32'(b_oob), 32'd1);
        check("oob x hold", 32'(b_vga_x), 32'd30);
        @(negedge clk);
        b_req0.valid = 1'b0;
        b_req1.valid = 1'b1; b_req1.x = 10'd1; b_req1.y = 9'd2; b_req1.color = 24'hABCDEF;
        #1;
        check("post-oob ready1", 32'(b_req1.ready), 32'd1);
        @(posedge clk);
        #1;
        check("post-oob plot", 32'({b_plot, b_vga_x, b_vga_y}), 32'({1'b1, 10'd1, 9'd2}));
        check("post-oob color", 32'(b_vga_color), 32'h00ABCDEF);
        check("oob sticky", 32'(b_oob), 32'd1);
        @(negedge clk);
        b_req1.valid = 1'b0;
        b_req0.valid = 1'b1; b_req0.x = 10'd3; b_req0.y = 9'd480;
        #1;
        check("oob y ready", 32'(b_req0.ready), 32'd1);
        @(posedge clk);
        #1;
        check("oob y plot", 32'(b_plot), 32'd0);
        check("oob y err", 32'(b_oob), 32'd1);
        @(negedge clk);
        b_req0.valid = 1'b0;

        // Random traffic against a round-robin reference model
        b_reset = 1'b1;
        @(posedge clk);
        #1;
        check("rerst oob", 32'(b_oob), 32'd0);
        @(negedge clk);
        b_reset = 1'b0;
        fav = 0; exp_oob = 1'b0;
        last_x = '0; last_y = '0; last_c = '0;
        p[0] = 1'b0; p[1] = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!p[k] && ($urandom_range(0, 99) < 65)) begin
                    p[k]  = 1'b1;
                    px[k] = 10'($urandom_range(0, 719));
                    py[k] = 9'($urandom_range(0, 511));
                    pc[k] = 24'($urandom);
                end
            end
            b_req0.valid = p[0]; b_req0.x = px[0]; b_req0.y = py[0]; b_req0.color = pc[0];
            b_req1.valid = p[1]; b_req1.x = px[1]; b_req1.y = py[1]; b_req1.color = pc[1];
            #1;
            g = -1;
            if (p[0] && p[1]) begin
                g   = fav;
                fav = 1 - fav;
            end else if (p[0]) begin
                g = 0;
            end else if (p[1]) begin
                g = 1;
            end
            check("rand ready0", 32'(b_req0.ready), 32'(g == 0));
            check("rand ready1", 32'(b_req1.ready), 32'(g == 1));
            @(posedge clk);
            #1;
            exp_plot = 1'b0;
            if (g >= 0) begin
                if (px[g] < 10'd640 && py[g] < 9'd480) begin
                    exp_plot = 1'b1;
                    last_x = px[g]; last_y = py[g]; last_c = pc[g];
                end else begin
                    exp_oob = 1'b1;
                end
                p[g] = 1'b0;
            end
            check("rand plot", 32'(b_plot), 32'(exp_plot));
            check("rand xy", 32'({b_vga_x, b_vga_y}), 32'({last_x, last_y}));
            check("rand color", 32'(b_vga_color), 32'(last_c));
            check("rand oob", 32'(b_oob), 32'(exp_oob));
        end
        @(negedge clk);
        b_req0.valid = 1'b0;
        b_req1.valid = 1'b0;

        // 4x3 clear with a held req1 and an ignored second clear_req
        @(negedge clk);
        s_clear_req = 1'b1; s_clear_color = 24'h00FF00;
        s_req1.x = 10'd2; s_req1.y = 9'd1; s_req1.color = 24'hABCDEF;
        @(posedge clk);
        #1;
        check("clr entry plot", 32'({s_plot, s_busy}), 32'd0);
        nplots = 0; done_cnt = 0; done_cyc = -1; done_idx = -1;
        busy_cnt = 0; early_ready = 0; req1_pending = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            s_clear_req   = (cyc == 5);
            s_clear_color = (cyc == 5) ? 24'hFF00FF : 24'h00FF00;
            s_req1.valid  = req1_pending;
            #1;
            r1_seen = s_req1.ready;
            if (done_cyc < 0) begin
                if (r1_seen) early_ready++;
            end else if (cyc == done_cyc + 1) begin
                check("clr ready at idle", 32'(r1_seen), 32'd1);
            end
            if (r1_seen) req1_pending = 1'b0;
            @(posedge clk);
            #1;
            if (s_busy) busy_cnt++;
            if (s_clear_done) begin
                done_cnt++;
                done_cyc = cyc;
                done_idx = s_plot ? nplots : -2;
            end
            if (s_plot && nplots < 32) begin
                lx[nplots] = s_vga_x; ly[nplots] = s_vga_y;
                lc[nplots] = s_vga_color; lb[nplots] = s_busy;
                nplots++;
            end
        end
        @(negedge clk);
        s_req1.valid = 1'b0;
        s_clear_req  = 1'b0;
        check("clr plot count", 32'(nplots), 32'd13);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("clr px%0d xy", i), 32'({lx[i], ly[i]}),
                  32'({10'(i % 4), 9'(i / 4)}));
            check($sformatf("clr px%0d color/busy", i), 32'({lb[i], lc[i]}),
                  32'({1'b1, 24'h00FF00}));
        end
        check("clr done count", 32'(done_cnt), 32'd1);
        check("clr done on last", 32'(done_idx), 32'd11);
        check("clr busy cycles", 32'(busy_cnt), 32'd12);
        check("clr early ready1", 32'(early_ready), 32'd0);
        check("clr req1 after", 32'({lx[12], ly[12]}), 32'({10'd2, 9'd1}));
        check("clr req1 color/busy", 32'({lb[12], lc[12]}), 32'({1'b0, 24'hABCDEF}));

        // Request and clear_req in the same cycle, then reset mid-clear
        @(negedge clk);
        s_req0.valid = 1'b1; s_req0.x = 10'd1; s_req0.y = 9'd1; s_req0.color = 24'h111111;
        s_clear_req = 1'b1; s_clear_color = 24'h0000FF;
        #1;
        check("same-cyc ready0", 32'(s_req0.ready), 32'd1);
        @(posedge clk);
        #1;
        check("same-cyc plot", 32'({s_plot, s_busy, s_vga_x, s_vga_y}),
              32'({1'b1, 1'b0, 10'd1, 9'd1}));
        check("same-cyc color", 32'(s_vga_color), 32'h00111111);
        @(negedge clk);
        s_req0.valid = 1'b0;
        s_clear_req  = 1'b0;
        nclr = 0;
        for (int cyc = 0; cyc < 20 && nclr < 5; cyc++) begin
            @(posedge clk);
            #1;
            if (s_plot) nclr++;
        end
        check("mid-clr reached", 32'(nclr), 32'd5);
        check("mid-clr px5", 32'({s_busy, s_vga_x, s_vga_y}), 32'({1'b1, 10'd0, 9'd1}));
        check("mid-clr color", 32'(s_vga_color), 32'h000000FF);
        @(negedge clk);
        s_reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort outputs", 32'({s_plot, s_busy, s_clear_done}), 32'd0);
        @(negedge clk);
        s_reset = 1'b0;
        stray = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(posedge clk);
            #1;
            if (s_plot || s_busy || s_clear_done) stray++;
        end
        check("abort no resume", 32'(stray), 32'd0);
        @(negedge clk);
        s_req0.valid = 1'b1; s_req0.x = 10'd3; s_req0.y = 9'd2; s_req0.color = 24'h777777;
        #1;
        check("post-abort ready0", 32'(s_req0.ready), 32'd1);
        @(posedge clk);
        #1;
        check("post-abort plot", 32'({s_plot, s_vga_x, s_vga_y}), 32'({1'b1, 10'd3, 9'd2}));
        check("post-abort color", 32'(s_vga_color), 32'h00777777);
        @(negedge clk);
        s_req0.valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
